// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// mem_port_arbiter : shares one single-port memory between fetch, data and
//                    loader requesters with fixed-latency sequencing.
// Revision: 1.0
// ============================================================================
module mem_port_arbiter #(
  parameter int          MEM_LATENCY   = 1,
  parameter int          STARVE_LIMIT  = 4,
  parameter logic [31:0] PROTECT_LIMIT = 32'h0000_0400
) (
  input  logic        pc_clk,
  input  logic        reset,
  input  logic        fetch_req,
  input  logic [31:0] fetch_addr,
  output logic        fetch_ack,
  input  logic        data_req,
  input  logic [31:0] data_addr,
  input  logic        data_we,
  input  logic [31:0] data_wdata,
  output logic        data_ack,
  output logic        data_err,
  input  logic        ldr_req,
  input  logic [31:0] ldr_addr,
  input  logic        ldr_we,
  input  logic [31:0] ldr_wdata,
  output logic        ldr_ack,
  output logic [31:0] rdata,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_in,
  output logic        mem_write_enable,
  input  logic [31:0] mem_data_out,
  output logic        busy,
  output logic [1:0]  grant_id
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  localparam logic [3:0] c_lat_init   = 4'(MEM_LATENCY);
  localparam logic [3:0] c_starve_lim = 4'(STARVE_LIMIT);
  localparam logic [1:0] c_id_none    = 2'd0;
  localparam logic [1:0] c_id_fetch   = 2'd1;
  localparam logic [1:0] c_id_data    = 2'd2;
  localparam logic [1:0] c_id_ldr     = 2'd3;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_we;
  logic        r_blocked;
  logic        r_first;
  logic [3:0]  r_lat_cnt;
  logic [3:0]  r_starve_cnt;
  logic [1:0]  r_grant_id;
  logic        r_fetch_ack;
  logic        r_data_ack;
  logic        r_data_err;
  logic        r_ldr_ack;
  logic [31:0] r_rdata;

  logic [1:0]  w_win;
  logic [31:0] w_sel_addr;
  logic [31:0] w_sel_wdata;
  logic        w_sel_we;
  logic        w_sel_blocked;
  logic        w_fetch_override;
  logic        w_last;

  // Fetch outranks data only once it has lost STARVE_LIMIT arbitrations in a row
  assign w_fetch_override = fetch_req && (r_starve_cnt == c_starve_lim);
  assign w_last           = (r_state == S_ACCESS) && (r_lat_cnt == 4'd1);

  always_comb begin
    w_win         = c_id_none;
    w_sel_addr    = fetch_addr;
    w_sel_wdata   = '0;
    w_sel_we      = 1'b0;
    w_sel_blocked = 1'b0;
    if (ldr_req) begin
      w_win       = c_id_ldr;
      w_sel_addr  = ldr_addr;
      w_sel_wdata = ldr_wdata;
      w_sel_we    = ldr_we;
    end else if (data_req && !w_fetch_override) begin
      w_win         = c_id_data;
      w_sel_addr    = data_addr;
      w_sel_wdata   = data_wdata;
      w_sel_we      = data_we;
      w_sel_blocked = data_we && (data_addr < PROTECT_LIMIT);
    end else if (fetch_req) begin
      w_win = c_id_fetch;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_win != c_id_none) w_state_nxt = S_ACCESS;
      S_ACCESS: if (w_last) w_state_nxt = S_RESP;
      S_RESP:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge pc_clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge pc_clk) begin
    if (!reset) begin
      r_addr       <= '0;
      r_wdata      <= '0;
      r_we         <= 1'b0;
      r_blocked    <= 1'b0;
      r_first      <= 1'b0;
      r_lat_cnt    <= '0;
      r_starve_cnt <= '0;
      r_grant_id   <= c_id_none;
      r_fetch_ack  <= 1'b0;
      r_data_ack   <= 1'b0;
      r_data_err   <= 1'b0;
      r_ldr_ack    <= 1'b0;
      r_rdata      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!fetch_req || (w_win == c_id_fetch))
            r_starve_cnt <= '0;
          else if (r_starve_cnt < c_starve_lim)
            r_starve_cnt <= r_starve_cnt + 4'd1;
          if (w_win != c_id_none) begin
            r_addr     <= w_sel_addr;
            r_wdata    <= w_sel_wdata;
            r_we       <= w_sel_we;
            r_blocked  <= w_sel_blocked;
            r_grant_id <= w_win;
            r_lat_cnt  <= c_lat_init;
            r_first    <= 1'b1;
          end
        end
        S_ACCESS: begin
          r_first   <= 1'b0;
          r_lat_cnt <= r_lat_cnt - 4'd1;
          if (w_last) begin
            r_rdata     <= r_we ? 32'd0 : mem_data_out;
            r_fetch_ack <= (r_grant_id == c_id_fetch);
            r_data_ack  <= (r_grant_id == c_id_data);
            r_ldr_ack   <= (r_grant_id == c_id_ldr);
            r_data_err  <= r_blocked;
          end
        end
        default: begin
          r_fetch_ack <= 1'b0;
          r_data_ack  <= 1'b0;
          r_ldr_ack   <= 1'b0;
          r_data_err  <= 1'b0;
          r_rdata     <= '0;
          r_grant_id  <= c_id_none;
        end
      endcase
    end
  end

  assign mem_address      = (r_state == S_ACCESS) ? r_addr  : 32'd0;
  assign mem_data_in      = (r_state == S_ACCESS) ? r_wdata : 32'd0;
  assign mem_write_enable = (r_state == S_ACCESS) && r_first && r_we && !r_blocked;
  assign busy             = (r_state != S_IDLE);
  assign grant_id         = r_grant_id;
  assign fetch_ack        = r_fetch_ack;
  assign data_ack         = r_data_ack;
  assign data_err         = r_data_err;
  assign ldr_ack          = r_ldr_ack;
  assign rdata            = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_port_arbiter : scoreboard bench for mem_port_arbiter, two instances
//                       (MEM_LATENCY 1 and 3) each with its own memory model.
// Revision: 1.0
// ============================================================================
module tb_mem_port_arbiter;

  typedef struct {
    int          dut;
    int          id;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        pc_clk = 1'b0;
  logic        reset[2];
  logic        fetch_req[2], data_req[2], ldr_req[2], data_we[2], ldr_we[2];
  logic [31:0] fetch_addr[2], data_addr[2], data_wdata[2], ldr_addr[2], ldr_wdata[2];
  logic        fetch_ack[2], data_ack[2], data_err[2], ldr_ack[2], mem_we[2], busy[2];
  logic [31:0] rdata[2], mem_addr[2], mem_din[2], mem_dout[2];
  logic [1:0]  grant_id[2];
  logic [31:0] mem0[1024];
  logic [31:0] mem1[1024];

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc_cnt  = 0;
  int   we_cnt[2];
  int   rem_f[2], rem_d[2], rem_l[2];

  always #5 pc_clk = ~pc_clk;
  always @(posedge pc_clk) cyc_cnt <= cyc_cnt + 1;

  mem_port_arbiter #(.MEM_LATENCY(1), .STARVE_LIMIT(4), .PROTECT_LIMIT(32'h0000_0400)) u_dut0 (
    .pc_clk(pc_clk), .reset(reset[0]),
    .fetch_req(fetch_req[0]), .fetch_addr(fetch_addr[0]), .fetch_ack(fetch_ack[0]),
    .data_req(data_req[0]), .data_addr(data_addr[0]), .data_we(data_we[0]),
    .data_wdata(data_wdata[0]), .data_ack(data_ack[0]), .data_err(data_err[0]),
    .ldr_req(ldr_req[0]), .ldr_addr(ldr_addr[0]), .ldr_we(ldr_we[0]),
    .ldr_wdata(ldr_wdata[0]), .ldr_ack(ldr_ack[0]), .rdata(rdata[0]),
    .mem_address(mem_addr[0]), .mem_data_in(mem_din[0]), .mem_write_enable(mem_we[0]),
    .mem_data_out(mem_dout[0]), .busy(busy[0]), .grant_id(grant_id[0])
  );

  mem_port_arbiter #(.MEM_LATENCY(3), .STARVE_LIMIT(4), .PROTECT_LIMIT(32'h0000_0400)) u_dut1 (
    .pc_clk(pc_clk), .reset(reset[1]),
    .fetch_req(fetch_req[1]), .fetch_addr(fetch_addr[1]), .fetch_ack(fetch_ack[1]),
    .data_req(data_req[1]), .data_addr(data_addr[1]), .data_we(data_we[1]),
    .data_wdata(data_wdata[1]), .data_ack(data_ack[1]), .data_err(data_err[1]),
    .ldr_req(ldr_req[1]), .ldr_addr(ldr_addr[1]), .ldr_we(ldr_we[1]),
    .ldr_wdata(ldr_wdata[1]), .ldr_ack(ldr_ack[1]), .rdata(rdata[1]),
    .mem_address(mem_addr[1]), .mem_data_in(mem_din[1]), .mem_write_enable(mem_we[1]),
    .mem_data_out(mem_dout[1]), .busy(busy[1]), .grant_id(grant_id[1])
  );

  // Word-addressed memories, combinational read, write on the clock edge
  assign mem_dout[0] = mem0[mem_addr[0][11:2]];
  assign mem_dout[1] = mem1[mem_addr[1][11:2]];
  always @(posedge pc_clk) if (mem_we[0]) mem0[mem_addr[0][11:2]] <= mem_din[0];
  always @(posedge pc_clk) if (mem_we[1]) mem1[mem_addr[1][11:2]] <= mem_din[1];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Requesters hold req until they have been acked rem_* times
  always @(negedge pc_clk) begin
    for (int d = 0; d < 2; d++) begin
      if (fetch_ack[d] && rem_f[d] > 0) begin
        rem_f[d]--;
        if (rem_f[d] == 0) fetch_req[d] = 1'b0;
      end
      if (data_ack[d] && rem_d[d] > 0) begin
        rem_d[d]--;
        if (rem_d[d] == 0) data_req[d] = 1'b0;
      end
      if (ldr_ack[d] && rem_l[d] > 0) begin
        rem_l[d]--;
        if (rem_l[d] == 0) ldr_req[d] = 1'b0;
      end
    end
  end

  // Scoreboard: every ack pops the oldest expectation
  always @(negedge pc_clk) begin
    for (int d = 0; d < 2; d++) begin
      if (mem_we[d]) we_cnt[d]++;
      if (fetch_ack[d] || data_ack[d] || ldr_ack[d]) begin
        int   obs_id;
        exp_t e;
        obs_id = ldr_ack[d] ? 3 : (data_ack[d] ? 2 : 1);
        check_val("ack_onehot", 32'(int'(fetch_ack[d]) + int'(data_ack[d]) + int'(ldr_ack[d])), 32'd1);
        if (sb.size() == 0) begin
          check_val("unexpected_ack", 32'(obs_id), 32'd0);
        end else begin
          e = sb.pop_front();
          check_val("sb_dut", 32'(d), 32'(e.dut));
          check_val("sb_ack_id", 32'(obs_id), 32'(e.id));
          check_val("sb_grant_id", {30'd0, grant_id[d]}, 32'(e.id));
          check_val("sb_rdata", rdata[d], e.rdata);
          check_val("sb_data_err", {31'd0, data_err[d]}, {31'd0, e.err});
        end
      end else if (data_err[d]) begin
        check_val("err_without_ack", 32'd1, 32'd0);
      end
    end
  end

  task automatic issue(input int d, input int which, input int n);
    case (which)
      1: begin rem_f[d] = n; fetch_req[d] = 1'b1; end
      2: begin rem_d[d] = n; data_req[d]  = 1'b1; end
      default: begin rem_l[d] = n; ldr_req[d] = 1'b1; end
    endcase
  endtask

  task automatic wait_ack(input int d, input int which, output int cyc);
    logic hit;
    hit = 1'b0;
    cyc = 0;
    for (int i = 0; i < 60 && !hit; i++) begin
      @(negedge pc_clk);
      hit = (which == 1) ? fetch_ack[d] : (which == 2) ? data_ack[d] : ldr_ack[d];
    end
    cyc = cyc_cnt;
    if (!hit) check_val("ack_timeout", 32'd0, 32'(which));
  endtask

  task automatic wait_idle(input int d);
    int n;
    n = 0;
    while ((rem_f[d] + rem_d[d] + rem_l[d] > 0 || busy[d]) && n < 400) begin
      @(negedge pc_clk);
      n++;
    end
    if (n >= 400) check_val("idle_timeout", 32'd1, 32'd0);
  endtask

  // Edges from the grant becoming visible to the ack becoming visible
  task automatic measure_lat(input int d, input int id, output int lat);
    int g, n;
    logic ackv;
    g = 0; n = 0; lat = -1; ackv = 1'b0;
    while (grant_id[d] != 2'(id) && n < 40) begin @(posedge pc_clk); #1; n++; end
    g = cyc_cnt;
    while (!ackv && n < 80) begin
      @(posedge pc_clk); #1; n++;
      ackv = (id == 1) ? fetch_ack[d] : (id == 2) ? data_ack[d] : ldr_ack[d];
    end
    if (ackv) lat = cyc_cnt - g;
  endtask

  initial begin
    int t_l, t_d, t_f, lat;
    for (int d = 0; d < 2; d++) begin
      reset[d] = 1'b0; fetch_req[d] = 1'b0; data_req[d] = 1'b0; ldr_req[d] = 1'b0;
      data_we[d] = 1'b0; ldr_we[d] = 1'b0; fetch_addr[d] = '0; data_addr[d] = '0;
      data_wdata[d] = '0; ldr_addr[d] = '0; ldr_wdata[d] = '0;
      rem_f[d] = 0; rem_d[d] = 0; rem_l[d] = 0; we_cnt[d] = 0;
    end
    for (int i = 0; i < 1024; i++) begin mem0[i] = '0; mem1[i] = '0; end
    mem0[4]   = 32'h0050_0093;
    mem0[8]   = 32'h0000_0033;
    mem0[64]  = 32'h1111_1111;
    mem0[512] = 32'hA5A5_0800;

    repeat (3) @(posedge pc_clk);
    #1;
    check_val("rst_busy", {31'd0, busy[0]}, 32'd0);
    check_val("rst_grant", {30'd0, grant_id[0]}, 32'd0);
    check_val("rst_acks", {29'd0, fetch_ack[0], data_ack[0], ldr_ack[0]}, 32'd0);
    check_val("rst_mem_we", {31'd0, mem_we[0]}, 32'd0);
    check_val("rst_rdata", rdata[0], 32'd0);
    @(negedge pc_clk);
    reset[0] = 1'b1; reset[1] = 1'b1;
    repeat (2) @(negedge pc_clk);

    // Single fetch, latency 1
    fetch_addr[0] = 32'h10;
    sb.push_back('{0, 1, 32'h0050_0093, 1'b0});
    issue(0, 1, 1);
    @(posedge pc_clk); #1;
    check_val("f1_grant", {30'd0, grant_id[0]}, 32'd1);
    check_val("f1_busy", {31'd0, busy[0]}, 32'd1);
    check_val("f1_noack_yet", {31'd0, fetch_ack[0]}, 32'd0);
    @(posedge pc_clk); #1;
    check_val("f1_ack", {31'd0, fetch_ack[0]}, 32'd1);
    check_val("f1_rdata", rdata[0], 32'h0050_0093);
    @(posedge pc_clk); #1;
    check_val("f1_busy_low", {31'd0, busy[0]}, 32'd0);
    check_val("f1_grant_clr", {30'd0, grant_id[0]}, 32'd0);
    wait_idle(0);

    // Starvation: data wins 4, fetch 5th, counter restarts after the fetch grant
    @(negedge pc_clk);
    data_addr[0] = 32'h800; data_we[0] = 1'b0;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 4; k++) sb.push_back('{0, 2, 32'hA5A5_0800, 1'b0});
      sb.push_back('{0, 1, 32'h0050_0093, 1'b0});
    end
    issue(0, 1, 2);
    issue(0, 2, 8);
    wait_idle(0);
    check_val("starve_sb_drained", 32'(sb.size()), 32'd0);

    // Protected store below the limit, then a legal store at the limit
    @(negedge pc_clk);
    data_addr[0] = 32'h100; data_we[0] = 1'b1; data_wdata[0] = 32'hDEAD_BEEF;
    we_cnt[0] = 0;
    sb.push_back('{0, 2, 32'd0, 1'b1});
    issue(0, 2, 1);
    wait_idle(0);
    check_val("prot_we_cnt", 32'(we_cnt[0]), 32'd0);
    check_val("prot_mem_kept", mem0[64], 32'h1111_1111);
    @(negedge pc_clk);
    data_addr[0] = 32'h400;
    we_cnt[0] = 0;
    sb.push_back('{0, 2, 32'd0, 1'b0});
    issue(0, 2, 1);
    wait_idle(0);
    check_val("store_we_cnt", 32'(we_cnt[0]), 32'd1);
    check_val("store_mem", mem0[256], 32'hDEAD_BEEF);
    data_we[0] = 1'b0;

    // Three requests on one edge: loader, data, fetch spaced MEM_LATENCY+2
    @(negedge pc_clk);
    ldr_addr[0] = 32'h20; ldr_we[0] = 1'b0; data_addr[0] = 32'h800; fetch_addr[0] = 32'h10;
    sb.push_back('{0, 3, 32'h0000_0033, 1'b0});
    sb.push_back('{0, 2, 32'hA5A5_0800, 1'b0});
    sb.push_back('{0, 1, 32'h0050_0093, 1'b0});
    issue(0, 3, 1); issue(0, 2, 1); issue(0, 1, 1);
    wait_ack(0, 3, t_l);
    wait_ack(0, 2, t_d);
    wait_ack(0, 1, t_f);
    check_val("sim_gap_ld", 32'(t_d - t_l), 32'd3);
    check_val("sim_gap_df", 32'(t_f - t_d), 32'd3);
    wait_idle(0);

    // Latency 3: loader write then fetch of the same word
    @(negedge pc_clk);
    ldr_addr[1] = 32'h0; ldr_we[1] = 1'b1; ldr_wdata[1] = 32'h1234_5678;
    sb.push_back('{1, 3, 32'd0, 1'b0});
    issue(1, 3, 1);
    measure_lat(1, 3, lat);
    check_val("l3_ldr_lat", 32'(lat), 32'd3);
    wait_idle(1);
    @(negedge pc_clk);
    fetch_addr[1] = 32'h0;
    sb.push_back('{1, 1, 32'h1234_5678, 1'b0});
    issue(1, 1, 1);
    measure_lat(1, 1, lat);
    check_val("l3_fetch_lat", 32'(lat), 32'd3);
    wait_idle(1);

    // Reset in the middle of a store's ACCESS phase: no ack may ever appear
    @(negedge pc_clk);
    data_addr[1] = 32'h500; data_we[1] = 1'b1; data_wdata[1] = 32'hCAFE_F00D;
    issue(1, 2, 1);
    @(posedge pc_clk); #1;
    check_val("abort_grant", {30'd0, grant_id[1]}, 32'd2);
    @(posedge pc_clk); #1;
    check_val("abort_in_access", {31'd0, busy[1]}, 32'd1);
    reset[1] = 1'b0; data_req[1] = 1'b0; rem_d[1] = 0;
    @(posedge pc_clk); #1;
    check_val("abort_busy", {31'd0, busy[1]}, 32'd0);
    check_val("abort_grant_clr", {30'd0, grant_id[1]}, 32'd0);
    check_val("abort_acks", {29'd0, fetch_ack[1], data_ack[1], ldr_ack[1]}, 32'd0);
    check_val("abort_mem_we", {31'd0, mem_we[1]}, 32'd0);
    @(negedge pc_clk);
    reset[1] = 1'b1;
    repeat (10) @(negedge pc_clk);
    check_val("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
